// File: rtl/traffic_pkg.sv
// traffic_pkg: light codes, approach indices and scheduler states shared by the phase scheduler
package traffic_pkg;
    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_GREEN  = 2'b10;
    localparam int DIR_N = 0;
    localparam int DIR_S = 1;
    localparam int DIR_E = 2;
    localparam int DIR_W = 3;
    typedef enum logic [1:0] {IDLE, GREEN, YELLOW, ALL_RED} state_e;
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction
endpackage

// File: rtl/phase_scheduler_if.sv
// phase_scheduler_if: sensor-side inputs and signal-head outputs of the scheduler
// EMERGENCY_PREEMPT_EN adds the emer request vector
interface phase_scheduler_if;
    logic       tick;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] Light_north;
    logic [1:0] Light_south;
    logic [1:0] Light_east;
    logic [1:0] Light_west;
`ifdef EMERGENCY_PREEMPT_EN
    logic [3:0] emer;
    modport master (output tick, req, emer, input grant, Light_north, Light_south, Light_east, Light_west);
    modport slave (input tick, req, emer, output grant, Light_north, Light_south, Light_east, Light_west);
`else
    modport master (output tick, req, input grant, Light_north, Light_south, Light_east, Light_west);
    modport slave (input tick, req, output grant, Light_north, Light_south, Light_east, Light_west);
`endif
endinterface

// File: rtl/rr_pick4.sv
// rr_pick4: round-robin pick of the first pending approach at or after ptr, wrapping modulo 4
module rr_pick4
    import traffic_pkg::*;
(
    input  logic [3:0] pending_i,
    input  logic [1:0] ptr_i,
    output logic [3:0] onehot_o,
    output logic [1:0] idx_o,
    output logic       valid_o
);
    always_comb begin
        idx_o = ptr_i;
        for (int k = 3; k >= 0; k--)
            if (pending_i[ptr_i + 2'(k)]) idx_o = ptr_i + 2'(k);
        valid_o = |pending_i;
        onehot_o = valid_o ? onehot4(idx_o) : 4'b0000;
    end
endmodule

// File: rtl/phase_scheduler.sv
// phase_scheduler: round-robin four-approach green/yellow/all-red sequencer with registered outputs
// EMERGENCY_PREEMPT_EN adds emer preemption of the green phase
module phase_scheduler
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN = 5,
    parameter int MAX_GREEN = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int CNT_W     = 6
) (
    input logic clk,
    input logic rst,
    phase_scheduler_if.slave bus
);
    localparam logic [CNT_W-1:0] MIN_G = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MAX_G = CNT_W'(MAX_GREEN);
    localparam logic [CNT_W-1:0] YEL_T = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] AR_T  = CNT_W'(ALLRED_T);
    state_e           state_q, state_d;
    logic [3:0]       pending_q, pending_d, grant_q, grant_d, nxt_oh, pick_oh;
    logic [CNT_W-1:0] timer_q, timer_d, t_inc, g_t;
    logic [1:0]       ptr_q, ptr_d, cur_q, cur_d, pick_ptr, pick_idx;
    logic [3:0][1:0]  light_q, light_d;
    logic             pick_v, go;
    assign t_inc    = timer_q + CNT_W'(bus.tick);
    assign g_t      = (timer_q >= MAX_G) ? MAX_G : t_inc;
    // leaving all-red searches from the approach after the one just served
    assign pick_ptr = (state_q == ALL_RED) ? cur_q + 2'd1 : ptr_q;
    rr_pick4 u_pick (
        .pending_i (pending_q),
        .ptr_i     (pick_ptr),
        .onehot_o  (pick_oh),
        .idx_o     (pick_idx),
        .valid_o   (pick_v)
    );
`ifdef EMERGENCY_PREEMPT_EN
    logic       emer_v;
    logic [1:0] emer_idx;
    assign emer_v   = |bus.emer;
    assign emer_idx = bus.emer[0] ? 2'd0 : bus.emer[1] ? 2'd1 : bus.emer[2] ? 2'd2 : 2'd3;
`endif
    always_comb begin
        state_d = state_q;
        timer_d = t_inc;
        cur_d   = cur_q;
        ptr_d   = ptr_q;
        nxt_oh  = onehot4(cur_q);
        go      = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (pick_v) begin
                    state_d = GREEN;
                    cur_d   = pick_idx;
                    nxt_oh  = pick_oh;
                end
`ifdef EMERGENCY_PREEMPT_EN
                if (emer_v) begin
                    state_d = GREEN;
                    cur_d   = emer_idx;
                    nxt_oh  = onehot4(emer_idx);
                end
`endif
            end
            GREEN: begin
                timer_d = g_t;
                go = |(pending_q & ~onehot4(cur_q)) && g_t >= MIN_G && (!bus.req[cur_q] || g_t >= MAX_G);
`ifdef EMERGENCY_PREEMPT_EN
                if (emer_v) go = emer_idx != cur_q;
`endif
                if (go) begin
                    state_d = YELLOW;
                    timer_d = '0;
                end
            end
            YELLOW: if (t_inc >= YEL_T) begin
                state_d = ALL_RED;
                timer_d = '0;
            end
            ALL_RED: if (t_inc >= AR_T) begin
                timer_d = '0;
                ptr_d   = cur_q + 2'd1;
                state_d = pick_v ? GREEN : IDLE;
                cur_d   = pick_v ? pick_idx : cur_q;
                nxt_oh  = pick_oh;
`ifdef EMERGENCY_PREEMPT_EN
                if (emer_v) begin
                    ptr_d   = ptr_q;
                    state_d = GREEN;
                    cur_d   = emer_idx;
                    nxt_oh  = onehot4(emer_idx);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        grant_d = (state_d == GREEN || state_d == YELLOW) ? nxt_oh : 4'b0000;
        // the green approach neither latches its own request nor keeps it pending
        pending_d = (pending_q | (bus.req & ~(state_q == GREEN ? onehot4(cur_q) : 4'b0000)))
                  & ~(state_d == GREEN ? nxt_oh : 4'b0000);
        for (int i = 0; i < 4; i++)
            light_d[i] = grant_d[i] ? (state_d == GREEN ? LIGHT_GREEN : LIGHT_YELLOW) : LIGHT_RED;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            timer_q   <= '0;
            ptr_q     <= '0;
            cur_q     <= '0;
            grant_q   <= '0;
            light_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            timer_q   <= timer_d;
            ptr_q     <= ptr_d;
            cur_q     <= cur_d;
            grant_q   <= grant_d;
            light_q   <= light_d;
        end
    end
    assign bus.grant       = grant_q;
    assign bus.Light_north = light_q[DIR_N];
    assign bus.Light_south = light_q[DIR_S];
    assign bus.Light_east  = light_q[DIR_E];
    assign bus.Light_west  = light_q[DIR_W];
endmodule

// File: tb/tb_phase_scheduler.sv
// tb_phase_scheduler: directed scenarios with a per-cycle expected-output scoreboard
// EMERGENCY_PREEMPT_EN also runs the preemption scenario
module tb_phase_scheduler;
    import traffic_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    phase_scheduler_if bus ();
    phase_scheduler dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct {
        logic [3:0] g;
        logic [7:0] l;
        string      tag;
    } exp_t;
    exp_t sb[$];
    int n_vec = 0;
    int n_err = 0;
    function automatic exp_t mk(input int a, input logic [1:0] c, input string tag);
        exp_t e;
        e.g = '0;
        e.l = '0;
        e.tag = tag;
        if (a >= 0) begin
            e.g[a] = 1'b1;
            e.l[2*a +: 2] = c;
        end
        return e;
    endfunction
    task automatic step(input logic [3:0] r, input int a, input logic [1:0] c, input string tag);
        exp_t e;
        logic [11:0] obs;
        bus.req = r;
        sb.push_back(mk(a, c, tag));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        obs = {bus.grant, bus.Light_west, bus.Light_east, bus.Light_south, bus.Light_north};
        n_vec++;
        assert (obs === {e.g, e.l}) else begin
            n_err++;
            $error("FAIL %s: observed grant=%b lights(WESN)=%b expected grant=%b lights(WESN)=%b",
                   e.tag, obs[11:8], obs[7:0], e.g, e.l);
        end
    endtask
    task automatic do_reset();
        rst = 1'b0;
        step(4'b0000, -1, LIGHT_RED, "reset");
        rst = 1'b1;
    endtask
    task automatic serve(input int a, input string tag);
        for (int i = 0; i < 5; i++) step(4'b0000, a, LIGHT_GREEN, tag);
        for (int i = 0; i < 3; i++) step(4'b0000, a, LIGHT_YELLOW, tag);
        step(4'b0000, -1, LIGHT_RED, tag);
    endtask
    initial begin
        bus.tick = 1'b1;
        bus.req  = 4'b0000;
`ifdef EMERGENCY_PREEMPT_EN
        bus.emer = 4'b0000;
`endif
        do_reset();
        for (int i = 0; i < 20; i++) step(4'b0000, -1, LIGHT_RED, "s1_idle");
        step(4'b0001, -1, LIGHT_RED, "s2_latch");
        for (int i = 0; i < 10; i++) step(4'b0000, DIR_N, LIGHT_GREEN, "s2_n_rest");
        do_reset();
        step(4'b0001, -1, LIGHT_RED, "s3_latch");
        for (int i = 0; i < 20; i++) step(4'b0101, DIR_N, LIGHT_GREEN, "s3_n_max_green");
        for (int i = 0; i < 3; i++) step(4'b0101, DIR_N, LIGHT_YELLOW, "s3_n_yellow");
        step(4'b0101, -1, LIGHT_RED, "s3_allred");
        step(4'b0101, DIR_E, LIGHT_GREEN, "s3_e_green");
        do_reset();
        step(4'b1111, -1, LIGHT_RED, "s4_latch");
        serve(DIR_N, "s4_n");
        serve(DIR_S, "s4_s");
        serve(DIR_E, "s4_e");
        for (int i = 0; i < 8; i++) step(4'b0000, DIR_W, LIGHT_GREEN, "s4_w_rest");
        do_reset();
        step(4'b1111, -1, LIGHT_RED, "s5_latch");
        serve(DIR_N, "s5_n");
        for (int i = 0; i < 5; i++) step(4'b0000, DIR_S, LIGHT_GREEN, "s5_s_green");
        step(4'b0000, DIR_S, LIGHT_YELLOW, "s5_s_yellow");
        rst = 1'b0;
        step(4'b0000, -1, LIGHT_RED, "s5_rst_mid_yellow");
        rst = 1'b1;
        for (int i = 0; i < 6; i++) step(4'b0000, -1, LIGHT_RED, "s5_no_green");
`ifdef EMERGENCY_PREEMPT_EN
        do_reset();
        step(4'b0001, -1, LIGHT_RED, "s6_latch");
        step(4'b0000, DIR_N, LIGHT_GREEN, "s6_n_t0");
        step(4'b0000, DIR_N, LIGHT_GREEN, "s6_n_t1");
        bus.emer = 4'b1000;
        for (int i = 0; i < 3; i++) step(4'b0000, DIR_N, LIGHT_YELLOW, "s6_n_preempt");
        step(4'b0000, -1, LIGHT_RED, "s6_allred");
        step(4'b0010, DIR_W, LIGHT_GREEN, "s6_w_green");
        for (int i = 0; i < 25; i++) step(4'b0000, DIR_W, LIGHT_GREEN, "s6_w_hold");
        bus.emer = 4'b0000;
        for (int i = 0; i < 3; i++) step(4'b0000, DIR_W, LIGHT_YELLOW, "s6_w_yellow");
        step(4'b0000, -1, LIGHT_RED, "s6_w_allred");
        step(4'b0000, DIR_S, LIGHT_GREEN, "s6_rr_resume");
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
